// File: rtl/min3_bit_serializer.sv
// Parallel-to-serial feeder for the bit-serial lowest-of-three selector.
// Streams a/b/c triplets MSB-first with a one-entry hold buffer so that frames can go out back-to-back.
module min3_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a,
    output logic             out_b,
    output logic             out_c,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_first,
    output logic             out_last,
    output logic [CNT_W-1:0] frames_done
);

    // state | meaning
    // IDLE  | shift engine empty, out_valid low
    // SHIFT | shift engine presenting a beat of the current frame
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sc, sa_nx, sb_nx, sc_nx;
    logic [WIDTH-1:0] ha, hb, hc, ha_nx, hb_nx, hc_nx;
    logic             hfull, hfull_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [CNT_W-1:0] cnt_nx;

    logic act, beat, last_beat, accept, engine_free;

    assign act         = (state == SHIFT);
    assign beat        = act && out_ready;
    assign last_beat   = beat && (idx == '0);
    assign accept      = in_valid && in_ready;
    assign engine_free = !act || last_beat;

    assign in_ready  = !hfull;
    assign out_valid = act;
    assign out_a     = sa[WIDTH-1];
    assign out_b     = sb[WIDTH-1];
    assign out_c     = sc[WIDTH-1];
    assign out_idx   = idx;
    // Gated with act so the flags read 0 while idle (idx rests at 0).
    assign out_first = act && (idx == IDX_MSB);
    assign out_last  = act && (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sa          <= '0;
            sb          <= '0;
            sc          <= '0;
            ha          <= '0;
            hb          <= '0;
            hc          <= '0;
            hfull       <= 1'b0;
            idx         <= '0;
            frames_done <= '0;
        end else begin
            state       <= state_nx;
            sa          <= sa_nx;
            sb          <= sb_nx;
            sc          <= sc_nx;
            ha          <= ha_nx;
            hb          <= hb_nx;
            hc          <= hc_nx;
            hfull       <= hfull_nx;
            idx         <= idx_nx;
            frames_done <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sa_nx    = sa;
        sb_nx    = sb;
        sc_nx    = sc;
        ha_nx    = ha;
        hb_nx    = hb;
        hc_nx    = hc;
        hfull_nx = hfull;
        idx_nx   = idx;
        cnt_nx   = frames_done;

        if (beat && !last_beat) begin
            sa_nx  = {sa[WIDTH-2:0], 1'b0};
            sb_nx  = {sb[WIDTH-2:0], 1'b0};
            sc_nx  = {sc[WIDTH-2:0], 1'b0};
            idx_nx = idx - IDX_W'(1);
        end

        if (last_beat) begin
            cnt_nx = frames_done + CNT_W'(1);
        end

        if (engine_free) begin
            // hfull can only be set while shifting, so here it implies a draining last beat.
            if (hfull) begin
                sa_nx    = ha;
                sb_nx    = hb;
                sc_nx    = hc;
                idx_nx   = IDX_MSB;
                hfull_nx = 1'b0;
                state_nx = SHIFT;
            end else if (accept) begin
                sa_nx    = in_a;
                sb_nx    = in_b;
                sc_nx    = in_c;
                idx_nx   = IDX_MSB;
                state_nx = SHIFT;
            end else begin
                idx_nx   = '0;
                state_nx = IDLE;
            end
        end else if (accept) begin
            ha_nx    = in_a;
            hb_nx    = in_b;
            hc_nx    = in_c;
            hfull_nx = 1'b1;
        end
    end

endmodule

// File: tb/tb_min3_bit_serializer.sv
// Directed bench for min3_bit_serializer: single frame, back-to-back, backpressure,
// mid-frame reset and frame-counter wrap (counter built 2 bits wide).
module tb_min3_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0, in_b = '0, in_c = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_a, out_b, out_c;
    logic [2:0] out_idx;
    logic       out_first, out_last;
    logic [1:0] frames_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit qa[$], qb[$], qc[$], qf[$], ql[$];
    int qi[$], qcyc[$];

    min3_bit_serializer #(.WIDTH(8), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_idx    (out_idx),
        .out_first  (out_first),
        .out_last   (out_last),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beats are recorded half a cycle before the edge that transfers them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            qa.push_back(out_a);
            qb.push_back(out_b);
            qc.push_back(out_c);
            qf.push_back(out_first);
            ql.push_back(out_last);
            qi.push_back(int'(out_idx));
            qcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); qc.delete(); qf.delete(); ql.delete(); qi.delete(); qcyc.delete();
    endtask

    function automatic logic [7:0] pack(input int which, input int off);
        logic [7:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (off + k < qa.size()) begin
                case (which)
                    0: w = {w[6:0], qa[off+k]};
                    1: w = {w[6:0], qb[off+k]};
                    2: w = {w[6:0], qc[off+k]};
                    3: w = {w[6:0], qf[off+k]};
                    default: w = {w[6:0], ql[off+k]};
                endcase
            end
        end
        return w;
    endfunction

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(1);
        clear_q();
    endtask

    // Returns #1 after the edge that accepted the triplet.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bit done;
        int tries;
        done = 0;
        tries = 0;
        in_a = a; in_b = b; in_c = c;
        in_valid = 1'b1;
        while (!done && tries < 40) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_first_last", 32'({out_first, out_last}), 32'd0);
        check("rst_frames", 32'(frames_done), 32'd0);
        do_reset();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // single frame
        out_ready = 1'b1;
        send(8'd22, 8'd22, 8'd9);
        ticks(10);
        check("t1_beats", 32'(qa.size()), 32'd8);
        check("t1_a", 32'(pack(0, 0)), 32'd22);
        check("t1_b", 32'(pack(1, 0)), 32'd22);
        check("t1_c", 32'(pack(2, 0)), 32'd9);
        check("t1_first", 32'(pack(3, 0)), 32'h80);
        check("t1_last", 32'(pack(4, 0)), 32'h01);
        for (int k = 0; k < 8; k++)
            if (k < qi.size()) check("t1_idx", 32'(qi[k]), 32'(7 - k));
        check("t1_frames", 32'(frames_done), 32'd1);
        check("t1_valid_after", 32'(out_valid), 32'd0);

        // back-to-back
        do_reset();
        out_ready = 1'b1;
        send(8'd22, 8'd22, 8'd9);
        send(8'd255, 8'd0, 8'd128);
        ticks(20);
        check("t2_beats", 32'(qa.size()), 32'd16);
        if (qcyc.size() == 16) check("t2_no_bubble", 32'(qcyc[15] - qcyc[0]), 32'd15);
        if (qa.size() >= 9) check("t2_b9", 32'({qf[8], qa[8], qb[8], qc[8]}), 32'b1101);
        check("t2_a1", 32'(pack(0, 0)), 32'd22);
        check("t2_c1", 32'(pack(2, 0)), 32'd9);
        check("t2_a2", 32'(pack(0, 8)), 32'd255);
        check("t2_b2", 32'(pack(1, 8)), 32'd0);
        check("t2_c2", 32'(pack(2, 8)), 32'd128);
        check("t2_first", 32'({pack(3, 0), pack(3, 8)}), 32'h8080);
        check("t2_frames", 32'(frames_done), 32'd2);

        // backpressure at beat 3 (idx 5) of (170,85,15)
        do_reset();
        out_ready = 1'b1;
        send(8'd170, 8'd85, 8'd15);
        ticks(2);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                in_a = 8'd60; in_b = 8'd61; in_c = 8'd62; in_valid = 1'b1;
            end else if (k == 1) begin
                in_a = 8'd7; in_b = 8'd7; in_c = 8'd7; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_idx", 32'(out_idx), 32'd5);
            check("t3_hold_bits", 32'({out_a, out_b, out_c}), 32'b100);
            if (k == 0) check("t3_hold_accept", 32'(in_ready), 32'd1);
            if (k == 1) check("t3_third_refused", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        ticks(25);
        check("t3_beats", 32'(qa.size()), 32'd16);
        check("t3_a1", 32'(pack(0, 0)), 32'd170);
        check("t3_b1", 32'(pack(1, 0)), 32'd85);
        check("t3_c1", 32'(pack(2, 0)), 32'd15);
        check("t3_a2", 32'(pack(0, 8)), 32'd60);
        check("t3_b2", 32'(pack(1, 8)), 32'd61);
        check("t3_c2", 32'(pack(2, 8)), 32'd62);
        check("t3_frames", 32'(frames_done), 32'd2);

        // reset mid-frame at beat 4
        do_reset();
        out_ready = 1'b1;
        send(8'd22, 8'd22, 8'd9);
        ticks(3);
        check("t4_pre_bit", 32'({out_valid, out_a, out_idx}), 32'b11100);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 32'(out_valid), 32'd0);
        check("t4_rst_bits", 32'({out_a, out_b, out_c}), 32'd0);
        check("t4_rst_idx", 32'(out_idx), 32'd0);
        check("t4_rst_flags", 32'({out_first, out_last}), 32'd0);
        check("t4_rst_frames", 32'(frames_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t4_in_ready", 32'(in_ready), 32'd1);
        ticks(1);
        check("t4_idle", 32'(out_valid), 32'd0);
        clear_q();
        send(8'd1, 8'd2, 8'd3);
        ticks(10);
        check("t4_beats", 32'(qa.size()), 32'd8);
        if (qi.size() > 0) check("t4_start_idx", 32'(qi[0]), 32'd7);
        check("t4_a", 32'(pack(0, 0)), 32'd1);
        check("t4_b", 32'(pack(1, 0)), 32'd2);
        check("t4_c", 32'(pack(2, 0)), 32'd3);
        check("t4_frames", 32'(frames_done), 32'd1);

        // frame counter wrap, CNT_W = 2
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            send(8'd0, 8'd0, 8'd0);
            ticks(9);
            check("t5_frames", 32'(frames_done), 32'((f + 1) % 4));
        end
        check("t5_beats", 32'(qa.size()), 32'd40);
        begin
            int ones;
            ones = 0;
            for (int k = 0; k < qa.size(); k++) ones += int'(qa[k]) + int'(qb[k]) + int'(qc[k]);
            check("t5_zero_bits", 32'(ones), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
